// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
//
// Shared definitions for the board I/O blocks.
//
// Contents:
//   SWITCH_WIDTH            - number of board switches (default switch_debouncer
//                             width)
//   DEBOUNCE_CYCLES_DEFAULT - default number of consecutive sample strobes a
//                             new switch level must hold before it is accepted
//   debounce_state_t        - per-bit debouncer FSM state
//   debounce_cnt_width()    - width of the per-bit qualification counter
// -----------------------------------------------------------------------------
package io_pkg;

    localparam int SWITCH_WIDTH            = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

    // STABLE: synchronized input agrees with the debounced level.
    // CHECK : synchronized input disagrees; the new level is being qualified.
    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } debounce_state_t;

    // The counter only has to reach cycles-1 (the accept point), so
    // $clog2(cycles) bits are enough. Floor at one bit so a degenerate
    // parameter still elaborates to a legal vector.
    function automatic int debounce_cnt_width(input int cycles);
        if (cycles < 2) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage : io_pkg

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
//
// Single-bit switch debouncer: two-flop synchronizer, two-state qualification
// FSM and a saturating-by-construction strobe counter. The debounced level is
// held here; the parent turns the accept strobe into change/edge pulses.
//
// Parameters:
//   STABLE_CYCLES - consecutive sample strobes needed to accept a new level
//                   (legal 2..65535)
//
// Ports:
//   clock     in  rising-edge clock
//   reset     in  asynchronous active-high reset
//   sample_en in  one-cycle sample strobe (tie high for full-rate sampling)
//   switch_in in  raw asynchronous switch level
//   level     out debounced, registered level
//   sync      out synchronized input (second synchronizer flop)
//   accept    out high in the cycle before the edge at which level takes sync;
//                 lets the parent register its pulses on that same edge
// -----------------------------------------------------------------------------
module debounce_bit
    import io_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic sample_en,
    input  logic switch_in,
    output logic level,
    output logic sync,
    output logic accept
);

    localparam int               CNT_W    = debounce_cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             meta_reg;
    logic             sync_reg;
    logic             level_reg;
    logic [CNT_W-1:0] cnt_reg;
    debounce_state_t  state_reg;

    logic             differ;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer. meta_reg may go metastable; only sync_reg is used.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= switch_in;
            sync_reg <= meta_reg;
        end
    end

    assign differ = sync_reg ^ level_reg;

    // The strobe that completes qualification. The counter holds the number
    // of strobes already seen during this disagreement, so reaching
    // STABLE_CYCLES-1 with a further strobe means STABLE_CYCLES in total.
    assign accept = (state_reg == CHECK) && differ && sample_en
                    && (cnt_reg == CNT_LAST);

    // -------------------------------------------------------------------------
    // Qualification FSM, counter and debounced level.
    //
    // Invariant: cnt_reg is zero whenever the FSM is in STABLE, because every
    // path into STABLE clears it. Since STABLE_CYCLES >= 2 the accept point
    // can only be reached from CHECK.
    //
    // In CHECK the counter cannot wrap: at CNT_LAST a strobe accepts (and
    // clears), and without a strobe the counter holds.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= STABLE;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else begin
            case (state_reg)
                STABLE: begin
                    if (differ) begin
                        // The first differing cycle already counts as a strobe
                        // if sample_en happens to be high.
                        state_reg <= CHECK;
                        cnt_reg   <= sample_en ? CNT_ONE : '0;
                    end else begin
                        cnt_reg   <= '0;
                    end
                end

                CHECK: begin
                    if (!differ) begin
                        // Input bounced back before qualifying: glitch rejected.
                        state_reg <= STABLE;
                        cnt_reg   <= '0;
                    end else if (accept) begin
                        level_reg <= sync_reg;
                        cnt_reg   <= '0;
                        state_reg <= STABLE;
                    end else if (sample_en) begin
                        cnt_reg   <= cnt_reg + CNT_ONE;
                    end
                end

                default: begin
                    state_reg <= STABLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign level = level_reg;
    assign sync  = sync_reg;

endmodule : debounce_bit

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Debounces WIDTH independent board switches for the CPU input port. Each bit
// is synchronized and must hold a new level for STABLE_CYCLES consecutive
// sample strobes before switch_out follows it. Bits accepted on the same edge
// update together and share one changed pulse.
//
// Build option:
//   SWITCH_DEBOUNCER_EDGE_EN - when defined, adds the per-bit rise/fall pulse
//                              ports and registers. switch_out and changed
//                              behave identically in both builds.
//
// Parameters:
//   WIDTH         - number of switch bits
//   STABLE_CYCLES - consecutive sample strobes needed to accept a new level
//                   (legal 2..65535)
//
// Ports:
//   clock      in  rising-edge clock
//   reset      in  asynchronous active-high reset
//   sample_en  in  one-cycle sample strobe (prescaler enable, or tie high)
//   switch_in  in  [WIDTH] raw asynchronous switches
//   switch_out out [WIDTH] debounced, registered switch levels
//   changed    out one-cycle pulse in the cycle any switch_out bit changes
//   rise       out [WIDTH] per-bit 0->1 pulse   (SWITCH_DEBOUNCER_EDGE_EN only)
//   fall       out [WIDTH] per-bit 1->0 pulse   (SWITCH_DEBOUNCER_EDGE_EN only)
//
// All pulses are registered and line up with the cycle in which switch_out
// shows its new value.
// -----------------------------------------------------------------------------
module switch_debouncer
    import io_pkg::*;
#(
    parameter int WIDTH         = SWITCH_WIDTH,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] switch_in,
    output logic [WIDTH-1:0] switch_out,
    output logic             changed
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    logic [WIDTH-1:0] level_vec;
    logic [WIDTH-1:0] sync_vec;
    logic [WIDTH-1:0] accept_vec;
    logic [WIDTH-1:0] new_vec;
    logic [WIDTH-1:0] diff_vec;
    logic             changed_reg;

    // -------------------------------------------------------------------------
    // One independent debouncer per switch.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .STABLE_CYCLES (STABLE_CYCLES)
            ) u_bit (
                .clock     (clock),
                .reset     (reset),
                .sample_en (sample_en),
                .switch_in (switch_in[gi]),
                .level     (level_vec[gi]),
                .sync      (sync_vec[gi]),
                .accept    (accept_vec[gi])
            );
        end
    endgenerate

    // The value switch_out will hold after the coming edge. Registering pulses
    // from this (rather than from switch_out itself) keeps them in the same
    // cycle as the new level instead of one cycle late.
    assign new_vec  = (accept_vec & sync_vec) | (~accept_vec & level_vec);
    assign diff_vec = new_vec ^ level_vec;

    assign switch_out = level_vec;
    assign changed    = changed_reg;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic [WIDTH-1:0] rise_reg;
    logic [WIDTH-1:0] fall_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            changed_reg <= 1'b0;
            rise_reg    <= '0;
            fall_reg    <= '0;
        end else begin
            changed_reg <= |diff_vec;
            rise_reg    <= new_vec & ~level_vec;
            fall_reg    <= ~new_vec & level_vec;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= |diff_vec;
        end
    end
`endif

endmodule : switch_debouncer

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of switch bits.
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 16, giving the number of consecutive sample strobes required to accept a new level; legal range 2..65535.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port sample_en, input, 1 bit: one-cycle sample strobe, e.g. the prescaler slow-clock enable; tie high for full-rate sampling.
REQ-006 The block SHALL have port switch_in, input, WIDTH bits: raw asynchronous board switches.
REQ-007 The block SHALL have port switch_out, output, WIDTH bits: debounced, registered switch levels consumed by the CPU input port.
REQ-008 The block SHALL have port changed, output, 1 bit: one-cycle pulse in the cycle any switch_out bit changes.
REQ-009 The block SHALL have ports rise and fall, outputs, WIDTH bits each: per-bit one-cycle edge pulses, present only under the macro in REQ-020.

Function
REQ-010 Each bit SHALL pass through a two-flop synchronizer; the second flop is "sync".
REQ-011 Each bit SHALL run a two-state FSM:
- STABLE: sync == switch_out.
- CHECK: sync != switch_out.
- STABLE->CHECK: on the first cycle sync differs.
- CHECK->STABLE: when sync returns to switch_out (glitch rejected), or when the new level is accepted.
REQ-012 Each bit SHALL have a counter of width $clog2(STABLE_CYCLES) with the following rules:
- Clears in any cycle where sync == switch_out, regardless of sample_en.
- Increments on each sample_en cycle while sync != switch_out.
- Never wraps.
REQ-013 When sample_en is high, sync != switch_out and counter == STABLE_CYCLES-1, the block SHALL load sync into switch_out at that edge and clear the counter to 0.
REQ-014 With sample_en tied high, a clean input change SHALL appear on switch_out exactly 2+STABLE_CYCLES rising edges after it is captured.
REQ-015 A level held for fewer than STABLE_CYCLES strobes SHALL leave switch_out unchanged and SHALL NOT pulse changed, rise or fall.
REQ-016 Bits SHALL be independent; bits accepted on the same edge SHALL update together and produce a single one-cycle changed pulse.
REQ-017 changed, rise and fall SHALL be registered and asserted in the same cycle switch_out takes its new value, for exactly one cycle.

Reset
REQ-018 On reset, the block SHALL clear to 0, immediately and asynchronously, all of: both synchronizer flops, the counters, switch_out, changed, rise and fall; all FSMs go to STABLE.
REQ-019 Reset asserted mid-count SHALL discard the count; after release, a switch held non-zero SHALL be re-qualified from count 0 and reported as a rising change.

Configuration
REQ-020 With macro SWITCH_DEBOUNCER_EDGE_EN defined, the rise and fall ports and their registers SHALL exist, where rise = new & ~old and fall = ~new & old per bit.
REQ-021 With SWITCH_DEBOUNCER_EDGE_EN undefined, the block SHALL omit the rise and fall ports and logic, and all other behaviour SHALL be unchanged.

Structure
REQ-022 The shared package io_pkg SHALL hold the following; the module SHALL take its parameter defaults from io_pkg:
- SWITCH_WIDTH = 4.
- DEBOUNCE_CYCLES_DEFAULT = 16.
- The FSM state enum debounce_state_t (STABLE, CHECK).
REQ-023 The per-bit synchronizer, FSM and counter SHALL be a sub-module debounce_bit, instantiated WIDTH times by a generate loop; change and edge pulse logic SHALL remain in switch_debouncer.

Verification (STABLE_CYCLES=4, sample_en=1 unless stated)
REQ-024 Reset with switch_in=4'b1000 held -> all outputs 0 during reset; switch_out=4'b1000 on the 6th edge after release; changed high one cycle; rise=4'b1000.
REQ-025 Glitch: bit0 high for 3 cycles then low -> switch_out stays 4'b0000; no changed, rise or fall pulse.
REQ-026 sample_en high every 2nd cycle, bit2 rises -> switch_out[2] updates on the 4th strobe after sync; counter holds between strobes.
REQ-027 Simultaneous: bits1 and bit2 rise in the same cycle -> both update on the same edge; single changed pulse; rise=4'b0110.
REQ-028 Reset pulse when bit3's counter = 2 -> immediate clear of all state; after release, switch_out[3] is requalified from 0 and updates 6 edges later.
REQ-029 Build with and without SWITCH_DEBOUNCER_EDGE_EN -> identical switch_out and changed traces for REQ-024..028.
